canvas_stream_out: RTL and testbench
====================================

# canvas_stream_out

Reads the 28x28 one-bit drawing canvas held by the VGA drawing front end and streams it, one pixel per transfer in row-major order, to the neural-network input layer over a valid/ready handshake. Each pixel is expanded to a DATA_W-bit activation. While streaming, the block accumulates the number of set pixels and their bounding box for later use by normalisation and debug. It sits directly downstream of the canvas memory and upstream of the first NN layer.

## Interface
- GRID_SIZE, 28, canvas side length in cells.
- PIXEL_COUNT, 784, GRID_SIZE*GRID_SIZE; index of last pixel is PIXEL_COUNT-1.
- DATA_W, 8, width of the streamed activation.
- ON_VALUE, 8'd255, activation for a set pixel. A clear pixel is 0.

- CLOCK_50  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- mem_addr  out  10  registered canvas read address, row*GRID_SIZE+col.
- mem_rdata  in  1  canvas read data, valid exactly one cycle after mem_addr changes.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the consumer accepts the current transfer.
- out_data  out  DATA_W  activation: ON_VALUE or 0.
- out_index  out  10  pixel index of the current transfer.
- out_last  out  1  asserted together with out_valid on index PIXEL_COUNT-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- pixel_count  out  10  number of set pixels accepted in the last frame.
- bbox_valid  out  1  at least one set pixel has been seen.
- bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y  out  5 each  bounding box of set pixels, in cell coordinates.

## Operation
- States: IDLE, FETCH, CAPTURE, SEND, FINISH.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1: clear idx, col, row, pixel_count, bbox_valid and all four bbox outputs to 0; set mem_addr=0; go to FETCH.
- FETCH: mem_addr holds idx; the memory read is in flight. Go to CAPTURE.
- CAPTURE:
  - Register out_data = mem_rdata ? ON_VALUE : 0.
  - Register out_index = idx and out_last = (idx==PIXEL_COUNT-1).
  - Go to SEND.
- SEND:
  - out_valid=1. out_data, out_index and out_last hold stable until accepted.
  - Acceptance is out_valid && out_ready in the same cycle.
  - On acceptance of a set pixel: increment pixel_count.
    - If bbox_valid=0: load all four bbox outputs with col/row and set bbox_valid=1.
    - Otherwise: update min and max by comparison.
  - On acceptance with out_last=1: go to FINISH.
  - On any other acceptance: idx+1. col wraps 27->0 and increments row. mem_addr <= idx+1. Go to FETCH.
  - No acceptance: remain in SEND.
- FINISH: done=1 for this single cycle. busy stays high in this cycle. Go to IDLE.
- col and row are counters, not derived by division. idx = row*28+col at all times.
- pixel_count saturates naturally: its maximum is 784, which fits in 10 bits.
- Statistics hold their values in IDLE until the next start.
- start while busy is ignored; no queueing.
- Reset from any state, including mid-SEND:
  - Go to IDLE.
  - out_valid=0, out_last=0, done=0, busy=0.
  - out_data=0, out_index=0, mem_addr=0.
  - pixel_count=0, bbox_valid=0, all bbox outputs 0.
  - No done pulse is produced for the aborted frame.

## Timing
- Cycle numbering: start sampled at cycle 0 -> FETCH at cycle 1 -> CAPTURE at cycle 2 -> first out_valid at cycle 3.
- With out_ready held at 1, each pixel takes 3 cycles (FETCH, CAPTURE, SEND).
- A full frame with out_ready=1: last transfer accepted at cycle 2352, done high at cycle 2353, busy=0 from cycle 2354.
- Each cycle out_ready is low in SEND adds one cycle. Data, index and last do not change while stalled.
- Statistics reflect an accepted transfer on the cycle after acceptance.
- All outputs are registered except out_valid and done, which are decoded from state only. Neither ever depends combinationally on an input.

## Test plan
- All-clear canvas, out_ready=1, start pulse -> 784 transfers, all out_data=0, out_last only on index 783, done at cycle 2353, pixel_count=0, bbox_valid=0.
- Single set cell at (x=5,y=9), i.e. index 257 -> exactly transfer 257 carries 255; pixel_count=1; bbox min=max=(5,9); bbox_valid=1.
- Set cells at (0,0), (27,27) and (3,20) -> pixel_count=3; bbox_min=(0,0); bbox_max=(27,27).
- Random out_ready stalls (about 50%) -> sequence identical to the unstalled run; payload stable while out_valid && !out_ready; frame length = 2353 + number of stall cycles.
- start pulsed again mid-frame -> ignored; indices continue monotonically; exactly one done.
- reset asserted while in SEND at index 400 -> next cycle IDLE with all outputs 0 and no done; a following start restreams from index 0.

Source files
------------

// File: rtl/canvas_stream_out.sv
// Streams the 28x28 one-bit drawing canvas to the NN input layer over valid/ready,
// expanding each cell to an activation and collecting set-pixel count and bounding box.
module canvas_stream_out #(
   parameter int unsigned GRID_SIZE = 28,
   parameter int unsigned DATA_W    = 8,
   parameter logic [DATA_W-1:0] ON_VALUE = DATA_W'(255)
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   output logic [9:0]        mem_addr,
   input  logic              mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [9:0]        out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [9:0]        pixel_count,
   output logic              bbox_valid,
   output logic [4:0]        bbox_min_x,
   output logic [4:0]        bbox_max_x,
   output logic [4:0]        bbox_min_y,
   output logic [4:0]        bbox_max_y
);

   localparam int unsigned PIXEL_COUNT = GRID_SIZE * GRID_SIZE;
   localparam logic [9:0]  LAST_IDX    = 10'(PIXEL_COUNT - 1);
   localparam logic [4:0]  LAST_COL    = 5'(GRID_SIZE - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_FINISH} state_t;

   state_t            state, state_next;
   logic [9:0]        idx, idx_next;
   logic [4:0]        col, col_next, row, row_next;
   logic [9:0]        mem_addr_next, out_index_next, pixel_count_next;
   logic [DATA_W-1:0] out_data_next;
   logic              out_last_next, busy_next, bbox_valid_next;
   logic [4:0]        bbox_min_x_next, bbox_max_x_next, bbox_min_y_next, bbox_max_y_next;

   // Handshake flags are pure state decodes so they never see an input combinationally
   assign out_valid = (state == S_SEND);
   assign done      = (state == S_FINISH);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         col         <= '0;
         row         <= '0;
         mem_addr    <= '0;
         out_data    <= '0;
         out_index   <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         pixel_count <= '0;
         bbox_valid  <= 1'b0;
         bbox_min_x  <= '0;
         bbox_max_x  <= '0;
         bbox_min_y  <= '0;
         bbox_max_y  <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         col         <= col_next;
         row         <= row_next;
         mem_addr    <= mem_addr_next;
         out_data    <= out_data_next;
         out_index   <= out_index_next;
         out_last    <= out_last_next;
         busy        <= busy_next;
         pixel_count <= pixel_count_next;
         bbox_valid  <= bbox_valid_next;
         bbox_min_x  <= bbox_min_x_next;
         bbox_max_x  <= bbox_max_x_next;
         bbox_min_y  <= bbox_min_y_next;
         bbox_max_y  <= bbox_max_y_next;
      end
   end

   always_comb begin
      state_next       = state;
      idx_next         = idx;
      col_next         = col;
      row_next         = row;
      mem_addr_next    = mem_addr;
      out_data_next    = out_data;
      out_index_next   = out_index;
      out_last_next    = out_last;
      pixel_count_next = pixel_count;
      bbox_valid_next  = bbox_valid;
      bbox_min_x_next  = bbox_min_x;
      bbox_max_x_next  = bbox_max_x;
      bbox_min_y_next  = bbox_min_y;
      bbox_max_y_next  = bbox_max_y;

      case (state)
         S_IDLE: begin
            if (start) begin
               idx_next         = '0;
               col_next         = '0;
               row_next         = '0;
               mem_addr_next    = '0;
               pixel_count_next = '0;
               bbox_valid_next  = 1'b0;
               bbox_min_x_next  = '0;
               bbox_max_x_next  = '0;
               bbox_min_y_next  = '0;
               bbox_max_y_next  = '0;
               state_next       = S_FETCH;
            end
         end
         S_FETCH: state_next = S_CAPTURE;
         S_CAPTURE: begin
            out_data_next  = mem_rdata ? ON_VALUE : '0;
            out_index_next = idx;
            out_last_next  = (idx == LAST_IDX);
            state_next     = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               // col/row still describe the pixel being accepted
               if (out_data != '0) begin
                  pixel_count_next = pixel_count + 10'd1;
                  bbox_valid_next  = 1'b1;
                  if (!bbox_valid) begin
                     bbox_min_x_next = col;
                     bbox_max_x_next = col;
                     bbox_min_y_next = row;
                     bbox_max_y_next = row;
                  end else begin
                     if (col < bbox_min_x) bbox_min_x_next = col;
                     if (col > bbox_max_x) bbox_max_x_next = col;
                     if (row < bbox_min_y) bbox_min_y_next = row;
                     if (row > bbox_max_y) bbox_max_y_next = row;
                  end
               end
               if (out_last) begin
                  state_next = S_FINISH;
               end else begin
                  idx_next      = idx + 10'd1;
                  mem_addr_next = idx + 10'd1;
                  if (col == LAST_COL) begin
                     col_next = '0;
                     row_next = row + 5'd1;
                  end else begin
                     col_next = col + 5'd1;
                  end
                  state_next = S_FETCH;
               end
            end
         end
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase

      busy_next = (state_next != S_IDLE);
   end

endmodule

// File: tb/tb_canvas_stream_out.sv
// Directed bench for canvas_stream_out: canvas memory model, per-scenario tasks with inline checks.
module tb_canvas_stream_out;

   logic       CLOCK_50 = 1'b0;
   logic       reset, start, mem_rdata, out_ready;
   logic [9:0] mem_addr, out_index, pixel_count;
   logic [7:0] out_data;
   logic       out_valid, out_last, busy, done, bbox_valid;
   logic [4:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;

   int total = 0;
   int bad   = 0;

   logic       canvas  [0:783];
   logic [7:0] q_data  [0:783];
   logic [9:0] q_index [0:783];
   logic       q_last  [0:783];
   int n_xfer, done_cnt, done_cyc, idle_cyc, stalls, unstable, timeout;
   logic busy_at_done;

   canvas_stream_out dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last),
      .busy(busy), .done(done), .pixel_count(pixel_count), .bbox_valid(bbox_valid),
      .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
      .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Synchronous-read canvas: data valid the cycle after the address
   always @(posedge CLOCK_50)
      mem_rdata <= (mem_addr < 10'd784) ? canvas[mem_addr] : 1'b0;

   task automatic clear_canvas();
      for (int k = 0; k < 784; k++) canvas[k] = 1'b0;
   endtask

   task automatic set_cell(input int x, input int y);
      canvas[y * 28 + x] = 1'b1;
   endtask

   function automatic int count_data_errs();
      int e = 0;
      for (int k = 0; k < 784; k++)
         if (q_data[k] !== (canvas[k] ? 8'd255 : 8'd0)) e++;
      return e;
   endfunction

   function automatic int count_seq_errs();
      int e = 0;
      for (int k = 0; k < 784; k++)
         if (q_index[k] !== 10'(k) || q_last[k] !== (k == 783)) e++;
      return e;
   endfunction

   // Drives one frame and records transfers; cycle 0 is the cycle start is sampled
   task automatic run_frame(input bit stall_en, input int restart_at);
      logic [7:0] h_data;
      logic [9:0] h_index;
      logic       h_last;
      bit         held;
      n_xfer = 0; done_cnt = 0; done_cyc = -1; idle_cyc = -1;
      stalls = 0; unstable = 0; timeout = 0; held = 0; busy_at_done = 1'b0;
      h_data = '0; h_index = '0; h_last = 1'b0;
      @(negedge CLOCK_50);
      start = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 1; cyc < 8000; cyc++) begin
         @(negedge CLOCK_50);
         start = (cyc == restart_at);
         out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (held && (out_data !== h_data || out_index !== h_index || out_last !== h_last))
               unstable++;
            if (out_ready) begin
               if (n_xfer < 784) begin
                  q_data[n_xfer]  = out_data;
                  q_index[n_xfer] = out_index;
                  q_last[n_xfer]  = out_last;
               end
               n_xfer++;
               held = 0;
            end else begin
               stalls++;
               held = 1;
               h_data = out_data; h_index = out_index; h_last = out_last;
            end
         end else begin
            held = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
         end
         if (done_cnt > 0 && !busy && !done) begin
            idle_cyc = cyc;
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
      timeout = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      clear_canvas();
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      @(negedge CLOCK_50);
      total++;
      if ({out_valid, busy, done, out_last, bbox_valid} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b expected 00000", {out_valid, busy, done, out_last, bbox_valid});
      end
      total++;
      if ({mem_addr, out_index, out_data, pixel_count} !== 38'd0) begin
         bad++;
         $display("FAIL reset_regs: addr=%0d idx=%0d data=%0d cnt=%0d expected all 0",
                  mem_addr, out_index, out_data, pixel_count);
      end
      total++;
      if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== 20'd0) begin
         bad++;
         $display("FAIL reset_bbox: got %h expected 0", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y});
      end
   endtask

   task automatic test_all_clear();
      int e;
      clear_canvas();
      run_frame(1'b0, 0);
      total++;
      if (timeout != 0 || n_xfer != 784) begin
         bad++;
         $display("FAIL clear_xfers: got %0d (timeout=%0d) expected 784", n_xfer, timeout);
      end
      e = count_data_errs();
      total++;
      if (e != 0) begin bad++; $display("FAIL clear_data: %0d bad pixels expected 0", e); end
      e = count_seq_errs();
      total++;
      if (e != 0) begin bad++; $display("FAIL clear_seq: %0d bad index/last expected 0", e); end
      total++;
      if (done_cyc != 2353 || idle_cyc != 2354 || busy_at_done !== 1'b1) begin
         bad++;
         $display("FAIL clear_timing: done=%0d idle=%0d busy@done=%b expected 2353 2354 1",
                  done_cyc, idle_cyc, busy_at_done);
      end
      total++;
      if (pixel_count !== 10'd0 || bbox_valid !== 1'b0) begin
         bad++;
         $display("FAIL clear_stats: cnt=%0d bv=%b expected 0 0", pixel_count, bbox_valid);
      end
   endtask

   task automatic test_single();
      int e;
      clear_canvas();
      set_cell(5, 9);
      run_frame(1'b0, 0);
      e = count_data_errs();
      total++;
      if (timeout != 0 || e != 0 || q_data[257] !== 8'd255) begin
         bad++;
         $display("FAIL single_data: errs=%0d d257=%0d expected 0 255", e, q_data[257]);
      end
      total++;
      if (pixel_count !== 10'd1 || bbox_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_stats: cnt=%0d bv=%b expected 1 1", pixel_count, bbox_valid);
      end
      total++;
      if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd5, 5'd5, 5'd9, 5'd9}) begin
         bad++;
         $display("FAIL single_bbox: x=%0d..%0d y=%0d..%0d expected 5..5 9..9",
                  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y);
      end
   endtask

   task automatic test_corners();
      int e;
      clear_canvas();
      set_cell(0, 0); set_cell(27, 27); set_cell(3, 20);
      run_frame(1'b0, 0);
      e = count_data_errs() + count_seq_errs();
      total++;
      if (timeout != 0 || e != 0) begin bad++; $display("FAIL corners_stream: %0d errors expected 0", e); end
      total++;
      if (pixel_count !== 10'd3) begin bad++; $display("FAIL corners_count: got %0d expected 3", pixel_count); end
      total++;
      if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd0, 5'd27, 5'd0, 5'd27}) begin
         bad++;
         $display("FAIL corners_bbox: x=%0d..%0d y=%0d..%0d expected 0..27 0..27",
                  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y);
      end
   endtask

   task automatic test_stall();
      int e;
      clear_canvas();
      set_cell(10, 4); set_cell(2, 15); set_cell(20, 8);
      run_frame(1'b1, 0);
      e = count_data_errs() + count_seq_errs();
      total++;
      if (timeout != 0 || n_xfer != 784 || e != 0) begin
         bad++;
         $display("FAIL stall_stream: xfers=%0d errs=%0d expected 784 0", n_xfer, e);
      end
      total++;
      if (stalls == 0 || unstable != 0) begin
         bad++;
         $display("FAIL stall_hold: stalls=%0d unstable=%0d expected >0 0", stalls, unstable);
      end
      total++;
      if (done_cyc != 2353 + stalls) begin
         bad++;
         $display("FAIL stall_length: done at %0d expected %0d", done_cyc, 2353 + stalls);
      end
      total++;
      if (pixel_count !== 10'd3 ||
          {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd2, 5'd20, 5'd4, 5'd15}) begin
         bad++;
         $display("FAIL stall_stats: cnt=%0d x=%0d..%0d y=%0d..%0d expected 3 2..20 4..15",
                  pixel_count, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y);
      end
   endtask

   task automatic test_restart_ignored();
      int e;
      run_frame(1'b0, 500);
      e = count_seq_errs();
      total++;
      if (timeout != 0 || done_cnt != 1 || e != 0 || done_cyc != 2353) begin
         bad++;
         $display("FAIL restart_frame: dones=%0d seq_errs=%0d done_cyc=%0d expected 1 0 2353",
                  done_cnt, e, done_cyc);
      end
      repeat (6) @(negedge CLOCK_50);
      total++;
      if (busy !== 1'b0 || pixel_count !== 10'd3 || bbox_max_x !== 5'd20) begin
         bad++;
         $display("FAIL restart_idle_hold: busy=%b cnt=%0d maxx=%0d expected 0 3 20",
                  busy, pixel_count, bbox_max_x);
      end
   endtask

   task automatic test_reset_mid();
      int found = 0;
      int dones = 0;
      clear_canvas();
      set_cell(0, 0); set_cell(27, 27); set_cell(3, 20);
      @(negedge CLOCK_50);
      start = 1'b1; out_ready = 1'b1;
      for (int cyc = 1; cyc < 3000 && found == 0; cyc++) begin
         @(negedge CLOCK_50);
         start = 1'b0;
         if (out_valid && out_index == 10'd400) begin
            out_ready = 1'b0;
            reset = 1'b1;
            found = 1;
         end
      end
      total++;
      if (found == 0) begin bad++; $display("FAIL rstmid_reach: index 400 never seen expected seen"); end
      @(negedge CLOCK_50);
      if (done) dones++;
      total++;
      if ({out_valid, busy, done, out_last, bbox_valid} !== 5'b0 ||
          {mem_addr, out_index, out_data, pixel_count} !== 38'd0 ||
          {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== 20'd0) begin
         bad++;
         $display("FAIL rstmid_outputs: v=%b b=%b idx=%0d addr=%0d data=%0d cnt=%0d bv=%b expected all 0",
                  out_valid, busy, out_index, mem_addr, out_data, pixel_count, bbox_valid);
      end
      reset = 1'b0;
      repeat (5) begin
         @(negedge CLOCK_50);
         if (done) dones++;
      end
      total++;
      if (dones != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); end
      run_frame(1'b0, 0);
      total++;
      if (timeout != 0 || n_xfer != 784 || count_seq_errs() != 0 || pixel_count !== 10'd3) begin
         bad++;
         $display("FAIL rstmid_restream: xfers=%0d first=%0d cnt=%0d expected 784 0 3",
                  n_xfer, q_index[0], pixel_count);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      test_reset();
      test_all_clear();
      test_single();
      test_corners();
      test_stall();
      test_restart_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
